// File: rtl/red_pitaya_fads_logger.sv
// FADS droplet record logger: FIFO of per-droplet records drained over sys bus.
// Records are four 32-bit words; software pops the head after reading it.
module red_pitaya_fads_logger #(
   parameter int AW = 4,
   parameter int IW = 14
) (
   input  logic          adc_clk_i,
   input  logic          adc_rstn_i,
   input  logic          evt_valid_i,
   input  logic [31:0]   evt_id_i,
   input  logic [31:0]   evt_time_i,
   input  logic [31:0]   evt_width_i,
   input  logic [IW-1:0] evt_intensity_i,
   input  logic [7:0]    evt_class_i,
   output logic          not_empty_o,
   output logic          overflow_o,
   input  logic [31:0]   sys_addr,
   input  logic [31:0]   sys_wdata,
   input  logic [3:0]    sys_sel,
   input  logic          sys_wen,
   input  logic          sys_ren,
   output logic [31:0]   sys_rdata,
   output logic          sys_err,
   output logic          sys_ack
);

   localparam int DEPTH = 1 << AW;
   localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

   logic [31:0] mem_id    [DEPTH];
   logic [31:0] mem_time  [DEPTH];
   logic [31:0] mem_width [DEPTH];
   logic [31:0] mem_info  [DEPTH];

   logic [AW-1:0] wp, rp, wp_n, rp_n;
   logic [AW:0]   count, count_n;
   logic          ovf, ovf_n, enable;
   logic [31:0]   dropped, dropped_n;
   logic [19:0]   addr;
   logic          full, empty, clr, pop_ok, want, push_ok, drop;
   logic [31:0]   info, rd;
   logic          unused_bits;

   assign addr  = sys_addr[19:0];
   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign info  = {evt_class_i, 8'h00,
                   {(16-IW){evt_intensity_i[IW-1]}}, evt_intensity_i};
   assign sys_err = 1'b0;
   assign unused_bits = ^{sys_sel, sys_addr[31:20], sys_wdata[31:2]};

   // A pop in the same cycle frees the slot a full-FIFO push needs.
   always_comb begin
      clr     = sys_wen && (addr == 20'h004) && sys_wdata[1];
      pop_ok  = sys_wen && (addr == 20'h020) && !empty;
      want    = evt_valid_i && enable && !clr;
      push_ok = want && (!full || pop_ok);
      drop    = want && full && !pop_ok;
      wp_n      = wp;
      rp_n      = rp;
      count_n   = count;
      ovf_n     = ovf;
      dropped_n = dropped;
      if (clr) begin
         wp_n      = '0;
         rp_n      = '0;
         count_n   = '0;
         ovf_n     = 1'b0;
         dropped_n = '0;
      end else begin
         if (push_ok) wp_n = wp + AW'(1);
         if (pop_ok)  rp_n = rp + AW'(1);
         if (push_ok && !pop_ok) count_n = count + (AW+1)'(1);
         if (pop_ok && !push_ok) count_n = count - (AW+1)'(1);
         if (drop) begin
            ovf_n = 1'b1;
            if (dropped != 32'hFFFF_FFFF) dropped_n = dropped + 32'd1;
         end
      end
   end

   always_comb begin
      rd = 32'h0;
      case (addr)
         20'h000: rd = {{(15-AW){1'b0}}, count, 13'b0, ovf, full, empty};
         20'h004: rd = {31'b0, enable};
         20'h008: rd = dropped;
         20'h010: rd = empty ? 32'h0 : mem_id[rp];
         20'h014: rd = empty ? 32'h0 : mem_time[rp];
         20'h018: rd = empty ? 32'h0 : mem_width[rp];
         20'h01C: rd = empty ? 32'h0 : mem_info[rp];
         20'h024: rd = {{(31-AW){1'b0}}, FULL_CNT};
         default: rd = 32'h0;
      endcase
   end

   always_ff @(posedge adc_clk_i) begin
      if (adc_rstn_i && push_ok) begin
         mem_id[wp]    <= evt_id_i;
         mem_time[wp]  <= evt_time_i;
         mem_width[wp] <= evt_width_i;
         mem_info[wp]  <= info;
      end
   end

   always_ff @(posedge adc_clk_i) begin
      if (!adc_rstn_i) begin
         wp          <= '0;
         rp          <= '0;
         count       <= '0;
         ovf         <= 1'b0;
         dropped     <= '0;
         enable      <= 1'b1;
         not_empty_o <= 1'b0;
         overflow_o  <= 1'b0;
         sys_ack     <= 1'b0;
         sys_rdata   <= '0;
      end else begin
         wp          <= wp_n;
         rp          <= rp_n;
         count       <= count_n;
         ovf         <= ovf_n;
         dropped     <= dropped_n;
         not_empty_o <= (count_n != '0);
         overflow_o  <= ovf_n;
         sys_ack     <= sys_wen | sys_ren;
         sys_rdata   <= sys_ren ? rd : 32'h0;
         if (sys_wen && (addr == 20'h004)) enable <= sys_wdata[0];
      end
   end

endmodule

// File: tb/tb_red_pitaya_fads_logger.sv
// Bench for red_pitaya_fads_logger: directed sequence with random record
// contents, checked against a queue-based model of the record FIFO.
module tb_red_pitaya_fads_logger;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        evt_valid = 1'b0;
   logic [31:0] evt_id = '0, evt_time = '0, evt_width = '0;
   logic [13:0] evt_int = '0;
   logic [7:0]  evt_class = '0;
   logic        not_empty, overflow;
   logic [31:0] sys_addr = '0, sys_wdata = '0;
   logic [3:0]  sys_sel = 4'hF;
   logic        sys_wen = 1'b0, sys_ren = 1'b0;
   logic [31:0] sys_rdata;
   logic        sys_err, sys_ack;

   int checks = 0;
   int errors = 0;

   logic [127:0] q[$];
   bit           m_en = 1'b1;
   bit           m_ovf = 1'b0;
   logic [31:0]  m_drop = '0;

   always #5 clk = ~clk;

   red_pitaya_fads_logger dut (
      .adc_clk_i(clk), .adc_rstn_i(rstn),
      .evt_valid_i(evt_valid), .evt_id_i(evt_id), .evt_time_i(evt_time),
      .evt_width_i(evt_width), .evt_intensity_i(evt_int),
      .evt_class_i(evt_class),
      .not_empty_o(not_empty), .overflow_o(overflow),
      .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_sel(sys_sel),
      .sys_wen(sys_wen), .sys_ren(sys_ren), .sys_rdata(sys_rdata),
      .sys_err(sys_err), .sys_ack(sys_ack)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] mk_rec(input logic [31:0] id,
                                           input int iv);
      logic [7:0]  cls;
      logic [15:0] i16;
      cls = 8'($urandom);
      i16 = 16'(iv);
      return {id, $urandom, $urandom, cls, 8'h00, i16};
   endfunction

   function automatic logic [31:0] word(input logic [127:0] r, input int k);
      return r[127-32*k -: 32];
   endfunction

   function automatic logic [31:0] exp_read(input logic [31:0] a);
      int n;
      n = q.size();
      case (a)
         32'h000: return {16'(n), 13'b0, m_ovf, n == 16, n == 0};
         32'h004: return {31'b0, m_en};
         32'h008: return m_drop;
         32'h010: return n > 0 ? word(q[0], 0) : 32'h0;
         32'h014: return n > 0 ? word(q[0], 1) : 32'h0;
         32'h018: return n > 0 ? word(q[0], 2) : 32'h0;
         32'h01C: return n > 0 ? word(q[0], 3) : 32'h0;
         32'h024: return 32'd16;
         default: return 32'h0;
      endcase
   endfunction

   // One clock with an optional event and an optional bus write.
   task automatic cycle(input bit v, input logic [127:0] r, input bit w,
                        input logic [31:0] a, input logic [31:0] d);
      bit clr, popv, was_full;
      evt_valid = v;
      evt_id    = word(r, 0);
      evt_time  = word(r, 1);
      evt_width = word(r, 2);
      evt_class = r[31:24];
      evt_int   = r[13:0];
      sys_wen   = w;
      sys_addr  = a;
      sys_wdata = d;
      step();
      evt_valid = 1'b0;
      sys_wen   = 1'b0;
      clr  = w && a == 32'h004 && d[1];
      popv = w && a == 32'h020 && q.size() > 0;
      was_full = q.size() == 16;
      if (clr) begin
         q.delete();
         m_drop = '0;
         m_ovf  = 1'b0;
      end else begin
         if (popv) void'(q.pop_front());
         if (v && m_en) begin
            if (!was_full || popv) q.push_back(r);
            else begin
               m_ovf = 1'b1;
               if (m_drop != 32'hFFFF_FFFF) m_drop++;
            end
         end
      end
      if (w && a == 32'h004) m_en = d[0];
      if (w) chk("ack_w", {31'b0, sys_ack}, 32'd1);
   endtask

   task automatic strobe(input logic [127:0] r);
      cycle(1'b1, r, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      cycle(1'b0, '0, 1'b1, a, d);
   endtask

   task automatic rd(input logic [31:0] a, input string tag);
      logic [31:0] e;
      e = exp_read(a);
      sys_ren  = 1'b1;
      sys_addr = a;
      step();
      sys_ren = 1'b0;
      chk("ack_r", {31'b0, sys_ack}, 32'd1);
      chk(tag, sys_rdata, e);
   endtask

   task automatic pins(input string tag);
      chk({tag, "_ne"}, {31'b0, not_empty}, {31'b0, q.size() > 0});
      chk({tag, "_ovf"}, {31'b0, overflow}, {31'b0, m_ovf});
      chk({tag, "_err"}, {31'b0, sys_err}, 32'd0);
   endtask

   initial begin
      logic [127:0] r;
      repeat (3) step();
      chk("rst_ack", {31'b0, sys_ack}, 32'd0);
      chk("rst_rdata", sys_rdata, 32'd0);
      pins("rst");
      rstn = 1'b1;
      step();

      strobe(mk_rec(32'd1, -5));
      strobe(mk_rec(32'd2, 100));
      strobe(mk_rec(32'd3, 8191));
      rd(32'h000, "status3");
      chk("status3_const", sys_rdata, 32'h0003_0000);
      rd(32'h010, "head_id");
      rd(32'h014, "head_time");
      rd(32'h018, "head_width");
      rd(32'h01C, "head_w3");
      chk("int_field", {16'h0, sys_rdata[15:0]}, 32'h0000_FFFB);
      rd(32'h024, "depth");
      rd(32'h004, "ctrl");
      rd(32'h030, "unmapped");
      wr(32'h020, $urandom);
      rd(32'h010, "head_after_pop");
      chk("head2_const", sys_rdata, 32'd2);

      wr(32'h004, 32'h3);
      rd(32'h000, "status_clr");
      for (int i = 0; i < 20; i++)
         strobe(mk_rec(32'd100 + 32'(i), int'($urandom_range(16383)) - 8192));
      rd(32'h000, "status_full");
      rd(32'h008, "dropped4");
      rd(32'h010, "head_full");
      step();
      pins("full");

      r = mk_rec(32'd999, 77);
      cycle(1'b1, r, 1'b1, 32'h020, 32'h0);
      rd(32'h000, "status_pp");
      rd(32'h008, "dropped_pp");
      for (int i = 0; i < 16; i++) begin
         rd(32'h010, "drain_id");
         if (i == 15) rd(32'h01C, "last_w3");
         wr(32'h020, 32'h0);
      end
      step();
      rd(32'h000, "status_empty");
      pins("empty");
      wr(32'h020, 32'h0);
      rd(32'h000, "status_xpop");
      rd(32'h010, "head_empty");
      pins("xpop");

      wr(32'h004, 32'h0);
      rd(32'h004, "ctrl_off");
      for (int i = 0; i < 5; i++) strobe(mk_rec($urandom, 1));
      rd(32'h000, "status_dis");
      rd(32'h008, "dropped_dis");
      wr(32'h004, 32'h1);
      strobe(mk_rec(32'd500, -8192));
      rd(32'h000, "status_en");
      rd(32'h01C, "w3_min");

      for (int i = 0; i < 18; i++) strobe(mk_rec($urandom, 3));
      rd(32'h008, "dropped_pre");
      cycle(1'b1, mk_rec(32'd42, 4), 1'b1, 32'h004, 32'h3);
      rd(32'h000, "status_clr2");
      rd(32'h008, "dropped_clr2");
      rd(32'h004, "ctrl_selfclr");
      step();
      pins("clr2");

      strobe(mk_rec(32'd7, 7));
      strobe(mk_rec(32'd8, 8));
      rstn      = 1'b0;
      evt_valid = 1'b1;
      sys_ren   = 1'b1;
      sys_addr  = 32'h0;
      step();
      evt_valid = 1'b0;
      sys_ren   = 1'b0;
      q.delete();
      m_en = 1'b1;
      m_ovf = 1'b0;
      m_drop = '0;
      chk("mrst_ack", {31'b0, sys_ack}, 32'd0);
      chk("mrst_rdata", sys_rdata, 32'd0);
      pins("mrst");
      rstn = 1'b1;
      step();
      rd(32'h000, "status_mrst");
      rd(32'h004, "ctrl_mrst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
